// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates one fetch port and one data port onto a single
// registered memory port. A transaction runs IDLE -> BUSY -> DONE -> IDLE.
// A grant is made only in IDLE. BUSY holds the memory strobes until
// mem_ready. DONE is the single cycle in which the requester's ack pulses.
//
// Optional feature: define ARB_RR_EN to replace fixed data-over-fetch
// priority with alternating (round-robin) priority on simultaneous requests.
// After reset the data port wins the first contended grant.

module mem_port_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [11:0] if_addr,
   output logic [15:0] if_rdata,
   output logic        if_ack,
   input  logic        d_rd,
   input  logic        d_wr,
   input  logic [11:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic [15:0] d_rdata,
   output logic        d_ack,
   output logic [11:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_rd,
   output logic        mem_wr,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ready,
   output logic        stall
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic d_pend;      // data port has a load or store outstanding
   logic any_pend;    // at least one port is requesting
   logic pick_data;   // arbitration result if a grant is made this cycle
   logic start;       // grant taken this cycle (IDLE with a request)
   logic finish;      // memory completes this cycle (BUSY with mem_ready)
   logic grant_data;  // owner of the transaction in flight: 1 = data port

   assign d_pend   = d_rd | d_wr;
   assign any_pend = if_req | d_pend;

   // Stall whenever a requester is waiting and is not seeing its ack
   assign stall = (if_req & ~if_ack) | (d_pend & ~d_ack);

`ifdef ARB_RR_EN
   logic last_data;   // 1 = the most recent grant went to the data port

   // Contention goes to the port that was not granted last
   always_comb begin
      pick_data = d_pend & (~if_req | ~last_data);
   end

   // Remember the winner of every grant; reset points at fetch so data wins first
   always_ff @(posedge clk) begin
      if (rst) begin
         last_data <= 1'b0;
      end else if (start) begin
         last_data <= pick_data;
      end
   end
`else
   // Fixed priority: the data port always beats the fetch port
   always_comb begin
      pick_data = d_pend;
   end
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; BUSY waits for mem_ready for as long as it takes
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (any_pend) begin
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (mem_ready) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Decoded control events for the datapath registers
   always_comb begin
      start  = 1'b0;
      finish = 1'b0;
      case (state)
         IDLE:    start  = any_pend;
         BUSY:    finish = mem_ready;
         default: begin
            start  = 1'b0;
            finish = 1'b0;
         end
      endcase
   end

   // Transaction owner, latched at grant time
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_data <= 1'b0;
      end else if (start) begin
         grant_data <= pick_data;
      end
   end

   // Memory address and write data, frozen from grant until the next grant
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (start) begin
         if (pick_data) begin
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
         end else begin
            mem_addr  <= if_addr;
            mem_wdata <= '0;
         end
      end
   end

   // Memory strobes: set on grant, dropped on completion; a store wins over a load
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_rd <= 1'b0;
         mem_wr <= 1'b0;
      end else if (start) begin
         mem_wr <= pick_data & d_wr;
         mem_rd <= ~(pick_data & d_wr);
      end else if (finish) begin
         mem_rd <= 1'b0;
         mem_wr <= 1'b0;
      end
   end

   // One-cycle completion pulse to whichever port owns the transaction
   always_ff @(posedge clk) begin
      if (rst) begin
         if_ack <= 1'b0;
         d_ack  <= 1'b0;
      end else begin
         if_ack <= finish & ~grant_data;
         d_ack  <= finish & grant_data;
      end
   end

   // Read data capture; a store leaves the data port's read register untouched
   always_ff @(posedge clk) begin
      if (rst) begin
         if_rdata <= '0;
         d_rdata  <= '0;
      end else if (finish) begin
         if (!grant_data) begin
            if_rdata <= mem_rdata;
         end else if (!mem_wr) begin
            d_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed tests for mem_port_arbiter. Cycle n begins
// 1 ns after the nth rising edge; inputs are driven there and outputs are
// compared 1 ns later, well away from the next edge.

`timescale 1ns/1ps

module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [11:0] if_addr;
   logic [15:0] if_rdata;
   logic        if_ack;
   logic        d_rd;
   logic        d_wr;
   logic [11:0] d_addr;
   logic [15:0] d_wdata;
   logic [15:0] d_rdata;
   logic        d_ack;
   logic [11:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_rd;
   logic        mem_wr;
   logic [15:0] mem_rdata;
   logic        mem_ready;
   logic        stall;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_ack    (if_ack),
      .d_rd      (d_rd),
      .d_wr      (d_wr),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_ack     (d_ack),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .stall     (stall)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; if_req = 0; if_addr = '0; d_rd = 0; d_wr = 0;
      d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 0;
      tick(); tick();
      #1;
      checks++;
      if ({mem_rd, mem_wr, if_ack, d_ack, stall} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 00000", {mem_rd, mem_wr, if_ack, d_ack, stall});
      end
      checks++;
      if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 60'h0) begin
         errors++;
         $display("FAIL reset_data got %h want 0", {mem_addr, mem_wdata, if_rdata, d_rdata});
      end
      rst = 1'b0;
   endtask

   task automatic test_fetch();
      tick();
      if_req = 1; if_addr = 12'h010;
      #1;
      checks++;
      if (stall !== 1'b1) begin errors++; $display("FAIL fetch_stall0 got %b want 1", stall); end
      tick();
      mem_ready = 1; mem_rdata = 16'h8102;
      #1;
      checks++;
      if ({mem_rd, mem_wr, mem_addr} !== {2'b10, 12'h010}) begin
         errors++; $display("FAIL fetch_strobe got rd=%b wr=%b addr=%h want 1 0 010", mem_rd, mem_wr, mem_addr);
      end
      tick();
      mem_ready = 0; mem_rdata = 16'h0000;
      #1;
      checks++;
      if ({if_ack, d_ack, if_rdata} !== {2'b10, 16'h8102}) begin
         errors++; $display("FAIL fetch_ack got if_ack=%b d_ack=%b rdata=%h want 1 0 8102", if_ack, d_ack, if_rdata);
      end
      checks++;
      if ({stall, mem_rd} !== 2'b00) begin
         errors++; $display("FAIL fetch_stall2 got stall=%b mem_rd=%b want 0 0", stall, mem_rd);
      end
      tick();
      if_req = 0;
      #1;
      checks++;
      if ({if_ack, mem_rd} !== 2'b00) begin
         errors++; $display("FAIL fetch_done got if_ack=%b mem_rd=%b want 0 0", if_ack, mem_rd);
      end
      tick();
      #1;
      checks++;
      if (mem_rd !== 1'b0) begin errors++; $display("FAIL fetch_no_regrant got %b want 0", mem_rd); end
   endtask

   task automatic test_load();
      d_rd = 1; d_addr = 12'h020;
      tick();
      mem_ready = 1; mem_rdata = 16'h1234;
      #1;
      checks++;
      if ({mem_rd, mem_wr, mem_addr} !== {2'b10, 12'h020}) begin
         errors++; $display("FAIL load_strobe got rd=%b wr=%b addr=%h want 1 0 020", mem_rd, mem_wr, mem_addr);
      end
      tick();
      mem_ready = 0;
      #1;
      checks++;
      if ({d_ack, if_ack, d_rdata} !== {2'b10, 16'h1234}) begin
         errors++; $display("FAIL load_ack got d_ack=%b if_ack=%b rdata=%h want 1 0 1234", d_ack, if_ack, d_rdata);
      end
      tick();
      d_rd = 0;
   endtask

   task automatic test_store_slow();
      d_wr = 1; d_addr = 12'h0FF; d_wdata = 16'hBEEF;
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (c == 2) begin d_addr = 12'h3A5; d_wdata = 16'h0F0F; end
         if (c == 4) begin mem_ready = 1; mem_rdata = 16'hDEAD; end
         #1;
         checks++;
         if ({mem_wr, mem_rd, mem_addr, mem_wdata} !== {2'b10, 12'h0FF, 16'hBEEF}) begin
            errors++;
            $display("FAIL store_hold_c%0d got wr=%b rd=%b addr=%h wdata=%h want 1 0 0ff beef",
                     c, mem_wr, mem_rd, mem_addr, mem_wdata);
         end
      end
      tick();
      mem_ready = 0;
      #1;
      checks++;
      if ({d_ack, if_ack, mem_wr, d_rdata} !== {3'b100, 16'h1234}) begin
         errors++; $display("FAIL store_ack got d_ack=%b if_ack=%b wr=%b rdata=%h want 1 0 0 1234",
                            d_ack, if_ack, mem_wr, d_rdata);
      end
      tick();
      d_wr = 0;
      #1;
      checks++;
      if (d_ack !== 1'b0) begin errors++; $display("FAIL store_ack_pulse got %b want 0", d_ack); end
   endtask

   task automatic test_conflict();
      d_rd = 1; d_wr = 1; d_addr = 12'h0AA; d_wdata = 16'h5555;
      tick();
      mem_ready = 1; mem_rdata = 16'h9999;
      #1;
      checks++;
      if ({mem_wr, mem_rd, mem_wdata} !== {2'b10, 16'h5555}) begin
         errors++; $display("FAIL conflict_strobe got wr=%b rd=%b wdata=%h want 1 0 5555", mem_wr, mem_rd, mem_wdata);
      end
      tick();
      mem_ready = 0;
      #1;
      checks++;
      if ({d_ack, mem_rd, d_rdata} !== {2'b10, 16'h1234}) begin
         errors++; $display("FAIL conflict_ack got d_ack=%b rd=%b rdata=%h want 1 0 1234", d_ack, mem_rd, d_rdata);
      end
      tick();
      d_rd = 0; d_wr = 0;
   endtask

   task automatic test_contention();
      do_reset();
      if_req = 1; if_addr = 12'h111; d_rd = 1; d_addr = 12'h222;
      tick();
      mem_ready = 1; mem_rdata = 16'h0A0A;
      #1;
      checks++;
      if ({mem_rd, mem_addr} !== {1'b1, 12'h222}) begin
         errors++; $display("FAIL contend_first got rd=%b addr=%h want 1 222", mem_rd, mem_addr);
      end
      tick();
      mem_ready = 0;
      #1;
      checks++;
      if ({d_ack, if_ack, stall, d_rdata} !== {3'b101, 16'h0A0A}) begin
         errors++; $display("FAIL contend_dack got d_ack=%b if_ack=%b stall=%b rdata=%h want 1 0 1 0a0a",
                            d_ack, if_ack, stall, d_rdata);
      end
      tick();
      d_rd = 0;
      #1;
      checks++;
      if ({mem_rd, stall} !== 2'b01) begin
         errors++; $display("FAIL contend_gap got rd=%b stall=%b want 0 1", mem_rd, stall);
      end
      tick();
      mem_ready = 1; mem_rdata = 16'h0B0B;
      #1;
      checks++;
      if ({mem_rd, mem_addr} !== {1'b1, 12'h111}) begin
         errors++; $display("FAIL contend_second got rd=%b addr=%h want 1 111", mem_rd, mem_addr);
      end
      tick();
      mem_ready = 0;
      #1;
      checks++;
      if ({if_ack, d_ack, if_rdata} !== {2'b10, 16'h0B0B}) begin
         errors++; $display("FAIL contend_iack got if_ack=%b d_ack=%b rdata=%h want 1 0 0b0b", if_ack, d_ack, if_rdata);
      end
      tick();
      if_req = 0;
   endtask

   task automatic test_reset_busy();
      tick();
      if_req = 1; if_addr = 12'h055;
      tick();
      tick();
      rst = 1; mem_ready = 1; mem_rdata = 16'h7777;
      #1;
      checks++;
      if (mem_rd !== 1'b1) begin errors++; $display("FAIL rstbusy_pre got %b want 1", mem_rd); end
      tick();
      rst = 0; mem_ready = 0; mem_rdata = 16'h0000;
      #1;
      checks++;
      if ({if_ack, d_ack, mem_rd, mem_addr, if_rdata} !== {3'b000, 12'h000, 16'h0000}) begin
         errors++; $display("FAIL rstbusy_abandon got if_ack=%b d_ack=%b rd=%b addr=%h rdata=%h want all 0",
                            if_ack, d_ack, mem_rd, mem_addr, if_rdata);
      end
      tick();
      mem_ready = 1; mem_rdata = 16'h4242;
      #1;
      checks++;
      if ({if_ack, mem_rd, mem_addr} !== {2'b01, 12'h055}) begin
         errors++; $display("FAIL rstbusy_regrant got if_ack=%b rd=%b addr=%h want 0 1 055", if_ack, mem_rd, mem_addr);
      end
      tick();
      mem_ready = 0;
      #1;
      checks++;
      if ({if_ack, if_rdata} !== {1'b1, 16'h4242}) begin
         errors++; $display("FAIL rstbusy_ack got if_ack=%b rdata=%h want 1 4242", if_ack, if_rdata);
      end
      tick();
      if_req = 0;
   endtask

   task automatic test_back_to_back();
      bit rr;
      bit exp_data;
`ifdef ARB_RR_EN
      rr = 1'b1;
`else
      rr = 1'b0;
`endif
      do_reset();
      if_req = 1; if_addr = 12'h300; d_rd = 1; d_addr = 12'h400;
      for (int i = 0; i < 6; i++) begin
         exp_data = rr ? (i % 2 == 0) : 1'b1;
         tick();
         mem_ready = 1; mem_rdata = 16'h1000 + 16'(i);
         #1;
         checks++;
         if ({mem_rd, mem_addr} !== {1'b1, (exp_data ? 12'h400 : 12'h300)}) begin
            errors++; $display("FAIL b2b_grant%0d got rd=%b addr=%h want data=%b", i, mem_rd, mem_addr, exp_data);
         end
         tick();
         mem_ready = 0;
         #1;
         checks++;
         if ({d_ack, if_ack} !== {exp_data, ~exp_data} ||
             (exp_data ? d_rdata : if_rdata) !== 16'h1000 + 16'(i)) begin
            errors++; $display("FAIL b2b_ack%0d got d_ack=%b if_ack=%b d_rdata=%h if_rdata=%h want data=%b",
                               i, d_ack, if_ack, d_rdata, if_rdata, exp_data);
         end
         tick();
      end
      if_req = 0; d_rd = 0;
      tick();
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_load();
      test_store_slow();
      test_conflict();
      test_contention();
      test_reset_busy();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
